// File: rtl/meter_time_controller.sv
// meter_time_controller
//   Remaining-time keeper for the parking meter. Credits coin pulses,
//   counts down on the 1 Hz strobe while a car is parked, clears the
//   balance on departure and drives a registered status FSM.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   tick_1hz   one-cycle strobe, once per second
//   coin[3:0]  one-cycle coin pulses (any combination may coincide)
//   parked     occupancy level, already synchronous to clk
//   time_left  remaining paid seconds, 0..MAX_SEC
//   state      0=IDLE 1=PAID 2=WARN 3=EXPIRED
//   blink      display blink enable
//   expired    high exactly when state is EXPIRED
module meter_time_controller #(
  parameter int MAX_SEC   = 9999,
  parameter int WARN_SEC  = 180,
  parameter int COIN0_SEC = 60,
  parameter int COIN1_SEC = 120,
  parameter int COIN2_SEC = 180,
  parameter int COIN3_SEC = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic [3:0]  coin,
  input  logic        parked,
  output logic [13:0] time_left,
  output logic [1:0]  state,
  output logic        blink,
  output logic        expired
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAID    = 2'd1,
    WARN    = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic signed [15:0] MAX_S  = 16'(MAX_SEC);
  localparam logic signed [15:0] C0_S   = 16'(COIN0_SEC);
  localparam logic signed [15:0] C1_S   = 16'(COIN1_SEC);
  localparam logic signed [15:0] C2_S   = 16'(COIN2_SEC);
  localparam logic signed [15:0] C3_S   = 16'(COIN3_SEC);
  localparam logic        [13:0] MAX_T  = 14'(MAX_SEC);
  localparam logic        [13:0] WARN_T = 14'(WARN_SEC);

  state_t             state_q;
  state_t             state_n;
  logic [13:0]        time_n;
  logic               blink_n;
  logic               parked_q;
  logic               depart_p0;
  logic               dec_p0;
  logic signed [15:0] add_p0;
  logic signed [15:0] sum_p0;

  // Clamp the signed balance into 0..MAX_SEC. The lower clamp cannot
  // trigger (decrement is gated on a non-zero balance) but keeps the
  // function total.
  function automatic logic [13:0] sat_time(input logic signed [15:0] v);
    if (v > MAX_S)
      return MAX_T;
    else if (v < 16'sd0)
      return 14'd0;
    else
      return v[13:0];
  endfunction

  // Stage p0: combinational next-balance, next-state and blink
  always_comb begin
    depart_p0 = parked_q & ~parked;
    dec_p0    = tick_1hz & parked & (time_left != 14'd0);

    add_p0 = 16'sd0;
    if (coin[0]) add_p0 = add_p0 + C0_S;
    if (coin[1]) add_p0 = add_p0 + C1_S;
    if (coin[2]) add_p0 = add_p0 + C2_S;
    if (coin[3]) add_p0 = add_p0 + C3_S;

    // decrement first, then credit, then saturate
    sum_p0 = $signed({2'b00, time_left}) - $signed({15'd0, dec_p0}) + add_p0;
    time_n = depart_p0 ? 14'd0 : sat_time(sum_p0);

    if (time_n == 14'd0)
      state_n = parked ? EXPIRED : IDLE;
    else if (time_n <= WARN_T)
      state_n = WARN;
    else
      state_n = PAID;

    blink_n = 1'b0;
    case (state_n)
      WARN: begin
        if (state_q != WARN)
          blink_n = 1'b1;
        else if (tick_1hz)
          blink_n = ~blink;
        else
          blink_n = blink;
      end
      EXPIRED: blink_n = 1'b1;
      default: blink_n = 1'b0;
    endcase
  end

  // Stage p1: registered outputs; time_left and state update together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_left <= 14'd0;
      state_q   <= IDLE;
      blink     <= 1'b0;
      expired   <= 1'b0;
      parked_q  <= 1'b0;
    end else begin
      time_left <= time_n;
      state_q   <= state_n;
      blink     <= blink_n;
      expired   <= (state_n == EXPIRED);
      parked_q  <= parked;
    end
  end

  assign state = state_q;

endmodule

// File: doc/meter_time_controller.md
Name: meter_time_controller

Overview:
Central timekeeping controller for the parking meter. It holds the remaining paid time in seconds, credits coin insertions, and counts down on a 1 Hz tick strobe while a car is parked. It clears the balance when the car departs and drives a registered status FSM (idle/paid/warning/expired) for the display and LED logic. It sits between the coin/sensor input conditioning and the seven-segment display path.

Parameters:
MAX_SEC, 9999, saturation ceiling for time_left (fits the 4-digit display)
WARN_SEC, 180, time_left at or below this value (and >0) is the warning region
COIN0_SEC, 60, seconds credited by coin[0]
COIN1_SEC, 120, seconds credited by coin[1]
COIN2_SEC, 180, seconds credited by coin[2]
COIN3_SEC, 300, seconds credited by coin[3]

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst_n  input  1  asynchronous, active-low reset
tick_1hz  input  1  one-clk-wide strobe, once per second
coin  input  4  one-clk-wide coin pulses; several bits may be high in the same cycle
parked  input  1  occupancy sensor level, already synchronised to clk
time_left  output  14  remaining paid seconds, 0..MAX_SEC
state  output  2  0=IDLE, 1=PAID, 2=WARN, 3=EXPIRED
blink  output  1  display blink enable
expired  output  1  high iff state==EXPIRED

Behaviour:
- Reset (rst_n=0, asynchronous): time_left=0, state=IDLE, blink=0, expired=0, internal parked_q=0. The block stays in reset for as long as rst_n is low, including mid-countdown.
- All outputs are registered. An input in cycle N is reflected on the outputs after clock edge N+1.
- depart = parked_q & ~parked (falling edge). parked_q updates every cycle.
- add = sum of COINk_SEC over every asserted coin[k]. Compute in ≥15 bits.
- dec = tick_1hz & parked & (time_left != 0).
- Next time value, in priority order:
  - depart: next = 0; coins in the same cycle are discarded.
  - otherwise: next = min(time_left - dec + add, MAX_SEC). Decrement is applied before add, then the result saturates.
- The tick is ignored while not parked (balance is frozen). Coins are credited whether or not the car is parked.
- State is computed from next time value and parked, and registered together with time_left so the two always agree:
  - next==0 & ~parked -> IDLE
  - next==0 & parked -> EXPIRED
  - 0<next<=WARN_SEC -> WARN
  - next>WARN_SEC -> PAID
- Countdown never wraps. time_left holds at 0.
- blink:
  - 0 in IDLE and PAID.
  - Forced to 1 on the cycle WARN is entered from another state.
  - While in WARN, toggles on each cycle with tick_1hz=1.
  - Constant 1 in EXPIRED.
- expired = (next state == EXPIRED), registered.
- Coin credit raising the balance from WARN above WARN_SEC returns the block to PAID with blink=0.
- Coin credit in EXPIRED leaves EXPIRED in the same update.

Test Plan:
- Reset/idle: assert rst_n=0 mid-countdown with time_left=500 -> outputs immediately 0/IDLE/blink 0/expired 0. Release, no inputs for 10 ticks -> unchanged.
- Credit and countdown: parked=1, pulse coin[1] -> time_left=120, state WARN, blink=1. Apply 5 ticks -> time_left=115, blink toggles each tick. Pulse coin[3] -> 415, PAID, blink=0.
- Saturation and simultaneity:
  - time_left=9950, parked=1, coin=4'b1111 with tick same cycle -> 9999.
  - time_left=9999, tick+coin[0] -> 9999.
  - time_left=10, tick+coin[0] -> 69.
- Expiry: parked=1, time_left=2, two ticks -> 1 then 0, state EXPIRED, expired=1, blink=1. Further ticks -> stays 0, no wrap to 16383.
- Departure: time_left=300, parked 1->0 with coin[2] pulsed on the falling-edge cycle -> time_left=0, IDLE, coin discarded. Ticks while parked=0 with time_left=60 (credited after) -> stays 60, state WARN.
- Arrival after reset: rst_n released with parked=1 -> no depart event, state EXPIRED after first edge, time_left=0.
